key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clk cycles per scan_clk half-period, legal range 1..2^20-1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; key-event queue depth, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  system clock; all logic is rising-edge on clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port scan_clk  output  1  divided clock driving the keypad scanner.
REQ-006 SHALL have port btn  input  16  debounced key levels from the scanner, bit n = key n, 1 = pressed, asynchronous to clk.
REQ-007 SHALL have port key_code  output  4  key index at queue head.
REQ-008 SHALL have port key_valid  output  1  queue non-empty.
REQ-009 SHALL have port key_ready  input  1  consumer accepts head.
REQ-010 SHALL have port key_held  output  1  any synchronized btn bit high.
REQ-011 SHALL have port overflow  output  1  sticky lost-event flag.
REQ-012 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-013 SHALL toggle scan_clk when a divider counter reaches SCAN_DIV-1, then reload the counter to 0, giving a period of 2*SCAN_DIV clk cycles.
REQ-014 SHALL pass btn through a 2-flop synchronizer (s1, s2) and keep a previous-value register prev <= s2.
REQ-015 SHALL define press[n] = s2[n] & ~prev[n]; releases generate no event.
REQ-016 SHALL hold a 16-bit pending mask; each cycle, pending <= (pending & ~grant) | press.
REQ-017 SHALL grant the lowest-index set pending bit when the queue is not full; at most one grant per cycle.
REQ-018 SHALL write the granted index into the queue in the same cycle as the grant.
REQ-019 SHALL block grants when count == FIFO_DEPTH, even if a pop occurs in the same cycle; pending bits are retained.
REQ-020 SHALL drive key_valid = (count != 0) and key_code = head entry; head is stable while key_valid & ~key_ready.
REQ-021 SHALL pop on key_valid & key_ready; simultaneous push and pop on a non-full, non-empty queue keeps count unchanged.
REQ-022 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-023 SHALL set overflow when press[n] occurs while pending[n] is already 1 and n is not granted that cycle; the event is dropped.
REQ-024 SHALL clear overflow on ovf_clr; a same-cycle set takes priority over the clear.
REQ-025 SHALL drive key_held = |s2.
REQ-026 SHALL have a latency from a btn bit rising before clk edge k to key_valid high after edge k+3, given an empty queue and no competing pending bits.

Reset
REQ-027 SHALL, while rst_n is low, force: scan_clk=0, divider=0, s1=s2=prev=0, pending=0, pointers=0, count=0, overflow=0.
REQ-028 SHALL drive key_valid=0, key_code=0 and key_held=0 during reset.
REQ-029 SHALL discard all queued and pending events when reset is asserted mid-operation; after deassertion, keys already held produce press events once synchronized.

Structure
REQ-030 SHALL take NUM_KEYS=16, KEY_W=4 and DEF_SCAN_DIV=50000 from shared package keypad_pkg.
REQ-031 SHALL implement the queue as sub-module key_fifo (parameterized depth and width; push/pop/full/empty/count).
REQ-032 SHALL keep the divider, synchronizer, edge detection, pending arbiter and overflow logic in key_event_ctrl.

Verification
REQ-033 SHALL cover: SCAN_DIV=3, 20 cycles after reset -> scan_clk period 6 clk, first rising edge after clk edge 3.
REQ-034 SHALL cover: key_ready=1, btn=0x0020 asserted before edge k -> key_valid=1, key_code=5 after edge k+3, for exactly 1 cycle.
REQ-035 SHALL cover: key_ready=0, btn=0x8001 in one cycle -> queue order 0 then 15; key_code stays 0 until key_ready pulses.
REQ-036 SHALL cover: key_ready=0, FIFO_DEPTH=4, keys 1,2,3,4,6 pressed in sequence -> queue holds 1,2,3,4 and pending[6]=1; after one pop, 6 is enqueued.
REQ-037 SHALL cover: queue full, key 6 pending, key 6 released and re-pressed -> overflow=1; ovf_clr pulse -> overflow=0.
REQ-038 SHALL cover: rst_n low for 1 cycle with 3 entries queued and btn=0x0004 held -> key_valid=0 immediately; key_code=2 valid 3 edges after release of reset.

Source files
------------

// File: rtl/key_event_ctrl_pkg.sv
// rtl/key_event_ctrl_pkg.sv - shared keypad constants and priority helpers
package keypad_pkg;

    localparam int NUM_KEYS     = 16;
    localparam int KEY_W        = 4;
    localparam int DEF_SCAN_DIV = 50000;
    localparam int DIV_W        = 20;

    // Isolate the lowest set bit; this is the fixed priority used by the arbiter
    function automatic logic [NUM_KEYS-1:0] lowest_onehot(input logic [NUM_KEYS-1:0] v);
        return v & (~v + {{(NUM_KEYS-1){1'b0}}, 1'b1});
    endfunction

    // Encode a one-hot (or zero) vector into a key index; zero encodes to 0
    function automatic logic [KEY_W-1:0] onehot_to_idx(input logic [NUM_KEYS-1:0] oh);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (oh[i]) begin
                idx = idx | i[KEY_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// rtl/key_event_ctrl_if.sv - key event stream between controller and consumer
interface key_event_ctrl_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );

endinterface

// File: rtl/key_event_ctrl_fifo.sv
// rtl/key_event_ctrl_fifo.sv - small circular queue of key indices
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage array; contents need no reset because empty gates every reader
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - keypad scan clock, press detection, arbitration and event queue
module key_event_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                scan_clk,
    input  logic [NUM_KEYS-1:0] btn,
    key_event_ctrl_if.master    kif,
    output logic                key_held,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_W-1:0]    r_div;
    logic                r_scan_clk;
    logic [NUM_KEYS-1:0] r_s1;
    logic [NUM_KEYS-1:0] r_s2;
    logic [NUM_KEYS-1:0] r_prev;
    logic [NUM_KEYS-1:0] r_pending;
    logic                r_overflow;

    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_grant;
    logic [KEY_W-1:0]    w_grant_idx;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_valid;
    logic [CNT_W-1:0]    w_count;
    logic [KEY_W-1:0]    w_head;
    logic                w_ovf_set;

    // Scan clock divider: toggle on terminal count, giving a 2*SCAN_DIV period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_scan_clk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div      <= '0;
            r_scan_clk <= ~r_scan_clk;
        end else begin
            r_div      <= r_div + DIV_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous key levels plus a history stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= btn;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Rising edges only; a release never produces an event
    assign w_press = r_s2 & ~r_prev;

    // A full queue blocks all grants, even when a pop happens the same cycle
    assign w_grant     = w_full ? '0 : lowest_onehot(r_pending);
    assign w_grant_idx = onehot_to_idx(w_grant);
    assign w_push      = |w_grant;

    // A press that lands on a still-pending, ungranted key is lost
    assign w_ovf_set = |(w_press & r_pending & ~w_grant);

    // Pending mask: retire the granted key, merge new presses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_press;
        end
    end

    // Sticky overflow flag; a new loss wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_grant_idx),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_valid       = (w_count != '0);
    assign w_pop         = w_valid & kif.key_ready;
    assign kif.key_valid = w_valid;
    assign kif.key_code  = w_empty ? '0 : w_head;
    assign scan_clk      = r_scan_clk;
    assign key_held      = |r_s2;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - directed scoreboard bench for key_event_ctrl
module tb_key_event_ctrl;
    import keypad_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                scan_clk;
    logic [NUM_KEYS-1:0] btn;
    logic                key_held;
    logic                overflow;
    logic                ovf_clr;

    int total;
    int bad;
    int sb[$];

    key_event_ctrl_if kif ();

    key_event_ctrl #(
        .SCAN_DIV   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_clk (scan_clk),
        .btn      (btn),
        .kif      (kif),
        .key_held (key_held),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Account for a handshake about to complete on the coming edge, then advance
    task automatic tick();
        int exp_code;
        if (kif.key_valid === 1'b1 && kif.key_ready === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%0h expected=no_event", kif.key_code);
            end
            if (sb.size() != 0) begin
                exp_code = sb.pop_front();
                check("sb_pop", 32'(kif.key_code), 32'(exp_code));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        btn           = '0;
        ovf_clr       = 1'b0;
        kif.key_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        tick();
        check("rst_valid",    32'(kif.key_valid), 32'h0);
        check("rst_code",     32'(kif.key_code),  32'h0);
        check("rst_held",     32'(key_held),      32'h0);
        check("rst_ovf",      32'(overflow),      32'h0);
        check("rst_scan_clk", 32'(scan_clk),      32'h0);

        // Scan clock: SCAN_DIV=3, first rise after edge 3, period 6
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("scan_clk_e%0d", e), 32'(scan_clk), 32'((e / 3) % 2));
        end

        // Single press with consumer ready: visible after edge k+3 for one cycle
        kif.key_ready = 1'b1;
        btn = 16'h0020;
        sb.push_back(5);
        ticks(3);
        check("lat_valid_k2", 32'(kif.key_valid), 32'h0);
        check("lat_held",     32'(key_held),      32'h1);
        tick();
        check("lat_valid_k3", 32'(kif.key_valid), 32'h1);
        check("lat_code_k3",  32'(kif.key_code),  32'h5);
        tick();
        check("lat_valid_k4", 32'(kif.key_valid), 32'h0);
        btn = '0;
        ticks(5);
        check("release_no_event", 32'(kif.key_valid), 32'h0);
        check("release_held",     32'(key_held),      32'h0);

        // Simultaneous presses queue in index order; head holds while not ready
        kif.key_ready = 1'b0;
        btn = 16'h8001;
        sb.push_back(0);
        sb.push_back(15);
        tick();
        btn = '0;
        ticks(3);
        check("pair_valid", 32'(kif.key_valid), 32'h1);
        check("pair_head0", 32'(kif.key_code),  32'h0);
        ticks(3);
        check("pair_hold0", 32'(kif.key_code),  32'h0);
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
        check("pair_head15", 32'(kif.key_code),  32'hF);
        check("pair_valid2", 32'(kif.key_valid), 32'h1);
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
        check("pair_drained", 32'(kif.key_valid), 32'h0);
        ticks(2);

        // Fill the queue: 1,2,3,4 stored, 6 left pending
        foreach (sb[i]) sb.delete(i);
        sb = {1, 2, 3, 4, 6};
        btn = '0;
        btn[1] = 1'b1; ticks(4);
        btn[2] = 1'b1; ticks(4);
        btn[3] = 1'b1; ticks(4);
        btn[4] = 1'b1; ticks(4);
        btn[6] = 1'b1; ticks(4);
        check("full_head",     32'(kif.key_code),     32'h1);
        check("full_pending6", 32'(dut.r_pending[6]), 32'h1);
        check("full_no_ovf",   32'(overflow),         32'h0);

        // Release and re-press key 6 while still pending: event lost
        btn = '0;
        ticks(3);
        btn = 16'h0040;
        ticks(4);
        check("ovf_set",      32'(overflow),         32'h1);
        ticks(2);
        check("ovf_sticky",   32'(overflow),         32'h1);
        check("ovf_pending6", 32'(dut.r_pending[6]), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared",  32'(overflow),         32'h0);

        // One pop frees a slot and the pending key is enqueued
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
        ticks(3);
        check("after_pop_head", 32'(kif.key_code), 32'h2);
        kif.key_ready = 1'b1;
        ticks(6);
        kif.key_ready = 1'b0;
        check("drain_valid", 32'(kif.key_valid), 32'h0);
        check("drain_sb",    32'(sb.size()),      32'h0);
        btn = '0;
        ticks(4);

        // Reset mid-operation with three queued entries and key 2 held
        btn = 16'h0380;
        tick();
        btn = '0;
        ticks(7);
        check("pre_rst_valid", 32'(kif.key_valid), 32'h1);
        check("pre_rst_head",  32'(kif.key_code),  32'h7);
        btn   = 16'h0004;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(kif.key_valid), 32'h0);
        check("mid_rst_code",  32'(kif.key_code),  32'h0);
        check("mid_rst_held",  32'(key_held),      32'h0);
        tick();
        rst_n = 1'b1;
        ticks(3);
        check("post_rst_valid_k2", 32'(kif.key_valid), 32'h0);
        check("post_rst_held",     32'(key_held),      32'h1);
        tick();
        check("post_rst_valid_k3", 32'(kif.key_valid), 32'h1);
        check("post_rst_code_k3",  32'(kif.key_code),  32'h2);
        sb.push_back(2);
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
        check("final_valid", 32'(kif.key_valid), 32'h0);
        check("final_sb",    32'(sb.size()),      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
